// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: 68030 asynchronous bus-cycle terminator with a table of address regions
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_ah / i_am / i_al      address bits 31:28, 19:16 (CPU-space type), 3:1 (IACK level)
//   i_fc                    function code
//   i_as_n                  address strobe
//   i_ext_dsack0/1_n        external acknowledge for size-11 regions and vectored IACK
//   o_cs_n                  registered region selects, active-low
//   o_iack_vec_n            acknowledge strobe to the vectoring device
//   o_dsack0_n/o_dsack1_n   data transfer acknowledge
//   o_avec_n                autovector request
//   o_berr_n                bus error (driven only when BERR_TIMEOUT_EN is defined)
// Optional: define BERR_TIMEOUT_EN to enable the TIMEOUT_CYCLES bus-error timeout.
module bus_cycle_controller #(
    parameter int NUM_REGIONS = 4,
    parameter int WS_WIDTH = 4,
    parameter logic [4*NUM_REGIONS-1:0] REGION_BASE = 16'hF80E,
    parameter logic [WS_WIDTH*NUM_REGIONS-1:0] REGION_WAIT = '0,
    parameter logic [2*NUM_REGIONS-1:0] REGION_SIZE = '0,
    parameter logic [6:0] VECTORED_LEVELS = 7'b0010000,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [3:0]             i_ah,
    input  logic [3:0]             i_am,
    input  logic [2:0]             i_al,
    input  logic [2:0]             i_fc,
    input  logic                   i_as_n,
    input  logic                   i_ext_dsack0_n,
    input  logic                   i_ext_dsack1_n,
    output logic [NUM_REGIONS-1:0] o_cs_n,
    output logic                   o_iack_vec_n,
    output logic                   o_dsack0_n,
    output logic                   o_dsack1_n,
    output logic                   o_avec_n,
    output logic                   o_berr_n
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;
    state_t r_state, w_next;
    logic [NUM_REGIONS-1:0] r_cs_n, w_cs_n, w_sel;
    logic [WS_WIDTH-1:0] r_cnt, w_cnt, w_wait;
    logic [1:0] r_size, w_size, w_rsize;
    logic r_none, w_none, w_hit;
    logic r_dsack0_n, r_dsack1_n, r_avec_n, r_iack_vec_n;
    logic w_dsack0_n, w_dsack1_n, w_avec_n, w_iack_vec_n;
    logic [7:0] w_vl;
    logic w_iack, w_vec;
    assign w_vl = {VECTORED_LEVELS, 1'b0};
    assign w_iack = (i_fc == 3'b111) && (i_am == 4'hF);
    assign w_vec = w_vl[i_al];
`ifdef BERR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic r_berr_n, w_berr_n;
`endif
    // Descending scan so the lowest matching region is the one that sticks.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '1;
        w_wait = '0;
        w_rsize = 2'b00;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (REGION_BASE[4*i +: 4] == i_ah) begin
                w_hit = 1'b1;
                w_sel = ~(NUM_REGIONS'(1) << i);
                w_wait = REGION_WAIT[WS_WIDTH*i +: WS_WIDTH];
                w_rsize = REGION_SIZE[2*i +: 2];
            end
        end
    end
    always_comb begin
        w_next = r_state;
        w_cs_n = r_cs_n;
        w_dsack0_n = r_dsack0_n;
        w_dsack1_n = r_dsack1_n;
        w_avec_n = r_avec_n;
        w_iack_vec_n = r_iack_vec_n;
        w_cnt = r_cnt;
        w_size = r_size;
        w_none = r_none;
`ifdef BERR_TIMEOUT_EN
        w_berr_n = r_berr_n;
`endif
        case (r_state)
            S_IDLE: begin
                if (!i_as_n) begin
                    // Size 11 doubles as "external acknowledge" mode.
                    w_next = S_WAIT;
                    w_size = 2'b11;
                    w_none = 1'b1;
                    w_cnt = '0;
                    if (w_iack) begin
                        if (w_vec) begin
                            w_iack_vec_n = 1'b0;
                            w_none = 1'b0;
                        end else begin
                            w_avec_n = 1'b0;
                            w_next = S_ACK;
                        end
                    end else if (i_fc != 3'b111 && w_hit) begin
                        w_cs_n = w_sel;
                        w_cnt = w_wait;
                        w_size = w_rsize;
                        w_none = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (r_none) begin
                    w_next = S_WAIT;
                end else if (r_size == 2'b11) begin
                    w_dsack0_n = i_ext_dsack0_n;
                    w_dsack1_n = i_ext_dsack1_n;
                    w_next = (!i_ext_dsack0_n || !i_ext_dsack1_n) ? S_ACK : S_WAIT;
                end else if (r_cnt == '0) begin
                    w_next = S_ACK;
                    w_dsack0_n = r_size == 2'b01;
                    w_dsack1_n = r_size == 2'b00;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
`ifdef BERR_TIMEOUT_EN
                if (w_next == S_WAIT && r_tcnt == TW'(TIMEOUT_CYCLES)) begin
                    w_next = S_ERR;
                    w_berr_n = 1'b0;
                end
`endif
            end
            default: w_next = r_state;
        endcase
        // AS_n negation ends the cycle from any non-idle state, abort included.
        if (r_state != S_IDLE && i_as_n) begin
            w_next = S_IDLE;
            w_cs_n = '1;
            w_dsack0_n = 1'b1;
            w_dsack1_n = 1'b1;
            w_avec_n = 1'b1;
            w_iack_vec_n = 1'b1;
`ifdef BERR_TIMEOUT_EN
            w_berr_n = 1'b1;
`endif
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cs_n <= '1;
            r_dsack0_n <= 1'b1;
            r_dsack1_n <= 1'b1;
            r_avec_n <= 1'b1;
            r_iack_vec_n <= 1'b1;
            r_cnt <= '0;
            r_size <= 2'b00;
            r_none <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cs_n <= w_cs_n;
            r_dsack0_n <= w_dsack0_n;
            r_dsack1_n <= w_dsack1_n;
            r_avec_n <= w_avec_n;
            r_iack_vec_n <= w_iack_vec_n;
            r_cnt <= w_cnt;
            r_size <= w_size;
            r_none <= w_none;
        end
    end
`ifdef BERR_TIMEOUT_EN
    // Holds the number of edges since IDLE exit while the cycle is open.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tcnt <= '0;
            r_berr_n <= 1'b1;
        end else begin
            r_tcnt <= (r_state == S_IDLE) ? TW'(1) : r_tcnt + TW'(1);
            r_berr_n <= w_berr_n;
        end
    end
    assign o_berr_n = r_berr_n;
`else
    assign o_berr_n = 1'b1;
`endif
    assign o_cs_n = r_cs_n;
    assign o_iack_vec_n = r_iack_vec_n;
    assign o_dsack0_n = r_dsack0_n;
    assign o_dsack1_n = r_dsack1_n;
    assign o_avec_n = r_avec_n;
endmodule

// File: tb/tb_bus_cycle_controller.sv
// tb_bus_cycle_controller: directed and randomized check of bus_cycle_controller against a cycle-level model
module tb_bus_cycle_controller;
    localparam int N = 5;
    localparam int TO = 16;
    localparam logic [4*N-1:0] P_BASE = {4'hE, 4'hF, 4'h8, 4'h0, 4'hE};
    localparam logic [4*N-1:0] P_WAIT = {4'd7, 4'd2, 4'd0, 4'd5, 4'd0};
    localparam logic [2*N-1:0] P_SIZE = {2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
    localparam logic [6:0] P_VL = 7'b0010000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] ah = 4'h0, am = 4'h0;
    logic [2:0] al = 3'd0, fc = 3'd5;
    logic as_n = 1'b1, ext0 = 1'b1, ext1 = 1'b1;
    logic [N-1:0] cs_n;
    logic iv, d0, d1, av, be;
    logic [N-1:0] e_cs = '1;
    logic e_iv = 1'b1, e_d0 = 1'b1, e_d1 = 1'b1, e_av = 1'b1, e_be = 1'b1;
    logic [N+4:0] dut_out, exp_out;
    int checks = 0, failures = 0;
    bit check_en = 1'b0;
    assign dut_out = {cs_n, iv, d0, d1, av, be};
    assign exp_out = {e_cs, e_iv, e_d0, e_d1, e_av, e_be};
    always #5 clk = ~clk;
    bus_cycle_controller #(
        .NUM_REGIONS(N), .WS_WIDTH(4), .REGION_BASE(P_BASE), .REGION_WAIT(P_WAIT),
        .REGION_SIZE(P_SIZE), .VECTORED_LEVELS(P_VL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ah(ah), .i_am(am), .i_al(al), .i_fc(fc), .i_as_n(as_n),
        .i_ext_dsack0_n(ext0), .i_ext_dsack1_n(ext1), .o_cs_n(cs_n), .o_iack_vec_n(iv),
        .o_dsack0_n(d0), .o_dsack1_n(d1), .o_avec_n(av), .o_berr_n(be)
    );
    // Model: a bus cycle is described by its kind, wait count and edges elapsed since it opened.
    bit busy = 1'b0, done = 1'b0, ext_mode = 1'b0, internal = 1'b0;
    int k = 0, w = 0, sz = 0, hit = -1, lvl = 0;
    logic [6:0] vl = P_VL;
    initial forever begin
        @(posedge clk);
        if (rst || (busy && as_n)) begin
            busy = 1'b0;
            {e_cs, e_iv, e_d0, e_d1, e_av, e_be} = '1;
        end else if (!busy) begin
            if (!as_n) begin
                busy = 1'b1; k = 0; done = 1'b0; ext_mode = 1'b0; internal = 1'b0; hit = -1;
                lvl = int'(al);
                if (fc == 3'd7 && am == 4'hF) begin
                    if (lvl != 0 && vl[lvl-1]) begin e_iv = 1'b0; ext_mode = 1'b1; end
                    else begin e_av = 1'b0; done = 1'b1; end
                end else if (fc != 3'd7) begin
                    for (int i = 0; i < N; i++) if (hit < 0 && P_BASE[4*i +: 4] == ah) hit = i;
                    if (hit >= 0) begin
                        e_cs[hit] = 1'b0;
                        w = int'(P_WAIT[4*hit +: 4]);
                        sz = int'(P_SIZE[2*hit +: 2]);
                        ext_mode = (sz == 3);
                        internal = (sz != 3);
                    end
                end
            end
        end else begin
            k++;
            if (!done && internal && k == w + 1) begin
                done = 1'b1;
                e_d0 = !(sz == 0 || sz == 2);
                e_d1 = !(sz == 1 || sz == 2);
            end else if (!done && ext_mode) begin
                e_d0 = ext0; e_d1 = ext1;
                if (!ext0 || !ext1) done = 1'b1;
            end
`ifdef BERR_TIMEOUT_EN
            if (!done && k == TO) begin e_be = 1'b0; done = 1'b1; end
`endif
        end
    end
    initial forever begin
        @(negedge clk);
        if (check_en) begin
            checks++;
            if (dut_out !== exp_out) begin
                failures++;
                $display("FAIL cycle t=%0t dut=%b model=%b", $time, dut_out, exp_out);
            end
        end
    end
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic lit(input string nm, input logic [N+4:0] want);
        checks++;
        if (dut_out !== want) begin failures++; $display("FAIL %s dut=%b want=%b", nm, dut_out, want); end
        checks++;
        if (exp_out !== want) begin failures++; $display("FAIL %s_model model=%b want=%b", nm, exp_out, want); end
    endtask
    int len, idle, pick;
    initial begin
        rst = 1'b1; as_n = 1'b0;
        tick(); tick();
        check_en = 1'b1;
        lit("reset", '1);
        rst = 1'b0; as_n = 1'b1; tick();
        ah = 4'hE; fc = 3'd5; as_n = 1'b0; tick();
        lit("r0_cs", {5'b11110, 5'b11111});
        tick();
        lit("r0_ack", {5'b11110, 5'b10111});
        as_n = 1'b1; tick();
        lit("r0_rel", '1);
        tick();
        fc = 3'd7; am = 4'hF; al = 3'd3; as_n = 1'b0; tick();
        lit("avec", {5'b11111, 5'b11101});
        as_n = 1'b1; tick();
        lit("avec_rel", '1);
        al = 3'd5; as_n = 1'b0; tick();
        lit("vec_iack", {5'b11111, 5'b01111});
        ext0 = 1'b0; tick();
        lit("vec_dsack", {5'b11111, 5'b00111});
        ext0 = 1'b1; as_n = 1'b1; tick();
        lit("vec_rel", '1);
        ah = 4'h0; fc = 3'd5; am = 4'h0; as_n = 1'b0; tick();
        lit("r1_cs", {5'b11101, 5'b11111});
        tick(); tick();
        lit("r1_wait", {5'b11101, 5'b11111});
        as_n = 1'b1; tick();
        lit("r1_abort", '1);
        ah = 4'h8; as_n = 1'b0; tick();
        lit("r2_cs", {5'b11011, 5'b11111});
        tick(); tick(); tick();
        lit("r2_wait", {5'b11011, 5'b11111});
        ext1 = 1'b0; tick();
        lit("r2_ext", {5'b11011, 5'b11011});
        ext1 = 1'b1; as_n = 1'b1; tick();
        lit("r2_rel", '1);
        ah = 4'h3; as_n = 1'b0; tick();
        for (int i = 0; i < 15; i++) tick();
        lit("nomatch_15", '1);
        tick();
`ifdef BERR_TIMEOUT_EN
        lit("timeout", {5'b11111, 5'b11110});
`else
        lit("no_timeout", '1);
`endif
        as_n = 1'b1; tick();
        lit("timeout_rel", '1);
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 5);
            ah = (pick == 0) ? 4'hE : (pick == 1) ? 4'h0 : (pick == 2) ? 4'h8 :
                 (pick == 3) ? 4'hF : 4'($urandom_range(0, 15));
            fc = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            am = (fc == 3'd7 && $urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            al = 3'($urandom_range(0, 7));
            as_n = 1'b0;
            len = $urandom_range(1, 24);
            for (int j = 0; j < len; j++) begin
                ext0 = ($urandom_range(0, 5) != 0);
                ext1 = ($urandom_range(0, 5) != 0);
                rst = ($urandom_range(0, 60) == 0);
                tick();
            end
            rst = 1'b0; as_n = 1'b1;
            idle = $urandom_range(1, 3);
            for (int j = 0; j < idle; j++) begin
                ah = 4'($urandom_range(0, 15));
                tick();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
